idex_stage: RTL

ID/EX pipeline stage of the cotm32 pipelined core: registers the decoded instruction from ID and detects load-use hazards. On a hazard it holds IF/ID and inserts one bubble into ID/EX. Its registered `o_idex_rs1_addr`/`o_idex_rs2_addr`/`o_idex_valid` feed the forwarding unit, and its payload feeds EX. A saturating bubble counter supports performance analysis.

---
 rtl/cotm32_pipeline_pkg.sv | 24 ++
 rtl/cotm32_pkg.sv | 8 +
 rtl/load_use_detect.sv | 25 ++
 rtl/idex_stage.sv | 132 +++++++++++++
 4 files changed

// File: rtl/cotm32_pipeline_pkg.sv
// Pipeline-register payload types for the cotm32 core.
package cotm32_pipeline_pkg;

    import cotm32_pkg::*;

    localparam int PIPE_IDEX_CTRL_W = 16;

    typedef struct packed {
        logic [XLEN-1:0]             pc;
        logic [RW-1:0]               rs1_addr;
        logic [RW-1:0]               rs2_addr;
        logic                        rs1_used;
        logic                        rs2_used;
        logic [XLEN-1:0]             rs1_data;
        logic [XLEN-1:0]             rs2_data;
        logic [XLEN-1:0]             imm;
        logic [RW-1:0]               rd_addr;
        logic                        regfile_we;
        logic                        mem_re;
        logic                        mem_we;
        logic [PIPE_IDEX_CTRL_W-1:0] ctrl;
    } idex_payload_t;

endpackage

// File: rtl/cotm32_pkg.sv
// Core-wide architectural constants shared by every cotm32 pipeline stage.
package cotm32_pkg;

    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;
    localparam int RW       = $clog2(NUM_REGS);

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard term: a load sitting in ID/EX whose rd is read by the ID instruction.
module load_use_detect
    import cotm32_pkg::*;
(
    input  logic          i_idex_valid,
    input  logic          i_idex_mem_re,
    input  logic [RW-1:0] i_idex_rd_addr,
    input  logic          i_ifid_valid,
    input  logic [RW-1:0] i_rs1_addr,
    input  logic          i_rs1_used,
    input  logic [RW-1:0] i_rs2_addr,
    input  logic          i_rs2_used,
    output logic          o_load_use
);

    logic rs1_match;
    logic rs2_match;

    // x0 is hardwired to zero, so a load targeting it never produces a value to wait for.
    assign rs1_match  = i_rs1_used && (i_rs1_addr == i_idex_rd_addr);
    assign rs2_match  = i_rs2_used && (i_rs2_addr == i_idex_rd_addr);
    assign o_load_use = i_idex_valid && i_idex_mem_re && (i_idex_rd_addr != '0)
                        && i_ifid_valid && (rs1_match || rs2_match);

endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and a saturating bubble counter.
module idex_stage
    import cotm32_pkg::*;
    import cotm32_pipeline_pkg::*;
#(
    parameter int CTRL_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ifid_valid,
    input  logic [XLEN-1:0]   i_id_pc,
    input  logic [RW-1:0]     i_id_rs1_addr,
    input  logic [RW-1:0]     i_id_rs2_addr,
    input  logic              i_id_rs1_used,
    input  logic              i_id_rs2_used,
    input  logic [XLEN-1:0]   i_id_rs1_data,
    input  logic [XLEN-1:0]   i_id_rs2_data,
    input  logic [XLEN-1:0]   i_id_imm,
    input  logic [RW-1:0]     i_id_rd_addr,
    input  logic              i_id_regfile_we,
    input  logic              i_id_mem_re,
    input  logic              i_id_mem_we,
    input  logic [CTRL_W-1:0] i_id_ctrl,
    input  logic              i_flush,
    input  logic              i_ex_stall,
    output logic              o_idex_valid,
    output logic [XLEN-1:0]   o_idex_pc,
    output logic [RW-1:0]     o_idex_rs1_addr,
    output logic [RW-1:0]     o_idex_rs2_addr,
    output logic              o_idex_rs1_used,
    output logic              o_idex_rs2_used,
    output logic [XLEN-1:0]   o_idex_rs1_data,
    output logic [XLEN-1:0]   o_idex_rs2_data,
    output logic [XLEN-1:0]   o_idex_imm,
    output logic [RW-1:0]     o_idex_rd_addr,
    output logic              o_idex_regfile_we,
    output logic              o_idex_mem_re,
    output logic              o_idex_mem_we,
    output logic [CTRL_W-1:0] o_idex_ctrl,
    output logic              o_ifid_stall,
    output logic              o_load_use,
    output logic [31:0]       o_bubble_cnt
);

    idex_payload_t payload_q, payload_d, id_payload;
    logic          valid_q, valid_d;
    logic [31:0]   bubble_cnt_q, bubble_cnt_d;

    load_use_detect u_load_use_detect (
        .i_idex_valid   (valid_q),
        .i_idex_mem_re  (payload_q.mem_re),
        .i_idex_rd_addr (payload_q.rd_addr),
        .i_ifid_valid   (i_ifid_valid),
        .i_rs1_addr     (i_id_rs1_addr),
        .i_rs1_used     (i_id_rs1_used),
        .i_rs2_addr     (i_id_rs2_addr),
        .i_rs2_used     (i_id_rs2_used),
        .o_load_use     (o_load_use)
    );

    // Handshake: an instruction moves ID -> ID/EX on an edge where o_ifid_stall is low and no flush
    // kills it; o_idex_valid marks a live slot and an invalid slot never carries write enables.
    assign o_ifid_stall = (o_load_use || i_ex_stall) && !i_flush;

    always_comb begin
        id_payload            = '0;
        id_payload.pc         = i_id_pc;
        id_payload.rs1_addr   = i_id_rs1_addr;
        id_payload.rs2_addr   = i_id_rs2_addr;
        id_payload.rs1_used   = i_id_rs1_used;
        id_payload.rs2_used   = i_id_rs2_used;
        id_payload.rs1_data   = i_id_rs1_data;
        id_payload.rs2_data   = i_id_rs2_data;
        id_payload.imm        = i_id_imm;
        id_payload.rd_addr    = i_id_rd_addr;
        id_payload.regfile_we = i_id_regfile_we && i_ifid_valid;
        id_payload.mem_re     = i_id_mem_re && i_ifid_valid;
        id_payload.mem_we     = i_id_mem_we && i_ifid_valid;
        id_payload.ctrl       = PIPE_IDEX_CTRL_W'(i_id_ctrl);
    end

    always_comb begin
        payload_d    = payload_q;
        valid_d      = valid_q;
        bubble_cnt_d = bubble_cnt_q;
        if (i_flush) begin
            payload_d = '0;
            valid_d   = 1'b0;
        end else if (i_ex_stall) begin
            // Hold everything; the hazard is re-evaluated against the same slot next cycle.
            payload_d = payload_q;
        end else if (o_load_use) begin
            payload_d = '0;
            valid_d   = 1'b0;
            if (bubble_cnt_q != 32'hFFFF_FFFF) begin
                bubble_cnt_d = bubble_cnt_q + 32'd1;
            end
        end else begin
            payload_d = id_payload;
            valid_d   = i_ifid_valid;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            payload_q    <= '0;
            valid_q      <= 1'b0;
            bubble_cnt_q <= '0;
        end else begin
            payload_q    <= payload_d;
            valid_q      <= valid_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign o_idex_valid      = valid_q;
    assign o_idex_pc         = payload_q.pc;
    assign o_idex_rs1_addr   = payload_q.rs1_addr;
    assign o_idex_rs2_addr   = payload_q.rs2_addr;
    assign o_idex_rs1_used   = payload_q.rs1_used;
    assign o_idex_rs2_used   = payload_q.rs2_used;
    assign o_idex_rs1_data   = payload_q.rs1_data;
    assign o_idex_rs2_data   = payload_q.rs2_data;
    assign o_idex_imm        = payload_q.imm;
    assign o_idex_rd_addr    = payload_q.rd_addr;
    assign o_idex_regfile_we = payload_q.regfile_we;
    assign o_idex_mem_re     = payload_q.mem_re;
    assign o_idex_mem_we     = payload_q.mem_we;
    assign o_idex_ctrl       = CTRL_W'(payload_q.ctrl);
    assign o_bubble_cnt      = bubble_cnt_q;

endmodule
